bus_control_logic: RTL and testbench
====================================

// Module: bus_control_logic
// PURPOSE
//  CPU-side bus interface of the 8259A: samples CS#/RD#/WR#/A0/D[7:0] and
//  tracks the ICW1..ICW4 initialisation sequence. Each completed write becomes
//  exactly one registered command pulse (ICW_1, ICW_2_4, OCW_1, OCW_2 or OCW_3)
//  plus latched internal_data_bus. It also drives the level read request.
//  Sits directly upstream of Control_Logic, whose same-named inputs it feeds.
// PARAMETERS
//  SYNC_STAGES  2  flops on cs/rd/wr/a0/data before edge detect (legal 1..3)
// PORTS
//  clk                input   1  system clock, all state on rising edge
//  reset_n            input   1  asynchronous active-low reset
//  chip_select_n      input   1  CS#, active low
//  read_enable_n      input   1  RD#, active low
//  write_enable_n     input   1  WR#, active low
//  address            input   1  A0
//  data_bus_in        input   8  CPU data D[7:0]
//  internal_data_bus  output  8  data of last committed write, held until next commit
//  ICW_1              output  1  one-cycle pulse, ICW1 committed
//  ICW_2_4            output  1  one-cycle pulse, ICW2/3/4 committed
//  OCW_1              output  1  one-cycle pulse, OCW1 (mask) committed
//  OCW_2              output  1  one-cycle pulse, OCW2 committed
//  OCW_3              output  1  one-cycle pulse, OCW3 committed
//  read               output  1  level: sampled ~cs_n & ~rd_n & ~(~wr_n)
//  init_done          output  1  1 when init FSM is in READY
// BEHAVIOUR
//  Reset: every output 0, internal_data_bus 8'h00, FSM=UNINIT, pipes inactive, armed=0.
//  Pipe: cs/rd/wr/a0/data shift through SYNC_STAGES flops.
//    wr_act = ~cs_n & ~wr_n at the last stage. prev_act = wr_act delayed one clk.
//  armed: set when wr_act=0 and cleared by reset.
//    A write already active at reset release is therefore discarded.
//  Capture: while wr_act=1, a0/data latch each clk, so the values of the
//    last active cycle are used.
//  Commit: prev_act & ~wr_act & armed. The decoded pulse and the
//    internal_data_bus update are registered on the next edge.
//    First edge sampling WR# (or CS#) high = E0; the pulse is high for the
//    single cycle starting at E(SYNC_STAGES). At most one pulse per commit.
//  Decode (D = captured data, A = captured a0):
//    A=0,D4=1     -> ICW_1. Latch SNGL=D1, IC4=D0. FSM->ICW2 from ANY state
//                    (restart mid-sequence allowed).
//    A=0,D4=0,D3=0 -> OCW_2 if READY, else ignored (no pulse, no bus update).
//    A=0,D4=0,D3=1 -> OCW_3 if READY, else ignored.
//    A=1: UNINIT -> ignored
//         ICW2 -> ICW_2_4. Next: ICW3 if SNGL=0, else ICW4 if IC4=1, else READY.
//         ICW3 -> ICW_2_4. Next: ICW4 if IC4=1, else READY.
//         ICW4 -> ICW_2_4. Next: READY.
//         READY -> OCW_1.
//  FSM states: UNINIT, ICW2, ICW3, ICW4, READY. Only ICW1 leaves UNINIT.
//  read: registered ~cs_n&~rd_n from last stage. If wr also active, read=0
//    (write wins). Not gated by FSM state.
//  Reset mid-sequence: FSM->UNINIT, and any pulse in flight is dropped.
//  CS# rising before WR# counts as the end of the write (commit).
//  Back-to-back writes need >=1 sampled inactive cycle between them.
// TESTING
//  T1 reset, ICW1 8'h13 (single, IC4), A0=1 8'h20, A0=1 8'h01 -> pulses ICW_1,
//     ICW_2_4, ICW_2_4. ICW3 skipped. init_done=1. bus=8'h01.
//  T2 ICW1 8'h10 (cascade, no IC4) then A0=1 8'h08, 8'h04 -> ICW_2_4 x2 ->
//     READY. Then A0=1 8'hFB -> OCW_1, bus=8'hFB.
//  T3 READY, A0=0 8'h20 -> OCW_2. A0=0 8'h0B -> OCW_3. Check each pulse is
//     exactly 1 clk wide at E(SYNC_STAGES).
//  T4 UNINIT, A0=1 8'hAA and A0=0 8'h20 -> no pulse, bus stays 8'h00.
//     ICW1 issued in state ICW3 -> FSM restarts at ICW2.
//  T5 assert reset_n low with WR# low, release, raise WR# -> no pulse.
//     RD#&WR# both low -> read=0.
//     RD# low for 5 clks -> read high 5 clks after the pipe delay.

Source files
------------

// File: rtl/bus_control_logic.sv
// 8259A CPU-side bus interface: synchronises CS#/RD#/WR#/A0/D, tracks the
// ICW1..ICW4 initialisation sequence and emits one registered command pulse per write.
module bus_control_logic #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       ICW_1,
  output logic       ICW_2_4,
  output logic       OCW_1,
  output logic       OCW_2,
  output logic       OCW_3,
  output logic       read,
  output logic       init_done
);

  localparam int unsigned L = SYNC_STAGES - 1;

  typedef enum logic [2:0] {
    UNINIT = 3'd0,
    ICW2   = 3'd1,
    ICW3   = 3'd2,
    ICW4   = 3'd3,
    READY  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0]      cs_pipe_q, cs_pipe_d;
  logic [SYNC_STAGES-1:0]      rd_pipe_q, rd_pipe_d;
  logic [SYNC_STAGES-1:0]      wr_pipe_q, wr_pipe_d;
  logic [SYNC_STAGES-1:0]      a0_pipe_q, a0_pipe_d;
  logic [SYNC_STAGES-1:0]      vld_pipe_q, vld_pipe_d;
  logic [SYNC_STAGES-1:0][7:0] data_pipe_q, data_pipe_d;

  logic       wr_act;
  logic       commit;
  logic       prev_act_q, prev_act_d;
  logic       armed_q, armed_d;
  logic       a0_cap_q, a0_cap_d;
  logic [7:0] data_cap_q, data_cap_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  state_t     state_q, state_d;
  logic [7:0] bus_q, bus_d;
  logic       icw1_q, icw1_d;
  logic       icw24_q, icw24_d;
  logic       ocw1_q, ocw1_d;
  logic       ocw2_q, ocw2_d;
  logic       ocw3_q, ocw3_d;
  logic       read_q, read_d;

  always_comb begin
    cs_pipe_d[0]   = chip_select_n;
    rd_pipe_d[0]   = read_enable_n;
    wr_pipe_d[0]   = write_enable_n;
    a0_pipe_d[0]   = address;
    vld_pipe_d[0]  = 1'b1;
    data_pipe_d[0] = data_bus_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      cs_pipe_d[i]   = cs_pipe_q[i-1];
      rd_pipe_d[i]   = rd_pipe_q[i-1];
      wr_pipe_d[i]   = wr_pipe_q[i-1];
      a0_pipe_d[i]   = a0_pipe_q[i-1];
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      data_pipe_d[i] = data_pipe_q[i-1];
    end
  end

  assign wr_act = ~cs_pipe_q[L] & ~wr_pipe_q[L];
  assign commit = prev_act_q & ~wr_act & armed_q;

  // Arming waits until the pipe holds real samples, so a write already
  // active at reset release is not mistaken for idle-then-write.
  always_comb begin
    prev_act_d = wr_act;
    armed_d    = armed_q | (vld_pipe_q[L] & ~wr_act);
    a0_cap_d   = wr_act ? a0_pipe_q[L]   : a0_cap_q;
    data_cap_d = wr_act ? data_pipe_q[L] : data_cap_q;
    read_d     = ~cs_pipe_q[L] & ~rd_pipe_q[L] & wr_pipe_q[L];
  end

  always_comb begin
    state_d = state_q;
    sngl_d  = sngl_q;
    ic4_d   = ic4_q;
    bus_d   = bus_q;
    icw1_d  = 1'b0;
    icw24_d = 1'b0;
    ocw1_d  = 1'b0;
    ocw2_d  = 1'b0;
    ocw3_d  = 1'b0;
    if (commit) begin
      if (!a0_cap_q) begin
        if (data_cap_q[4]) begin
          icw1_d  = 1'b1;
          bus_d   = data_cap_q;
          sngl_d  = data_cap_q[1];
          ic4_d   = data_cap_q[0];
          state_d = ICW2;
        end else if (state_q == READY) begin
          bus_d  = data_cap_q;
          ocw3_d = data_cap_q[3];
          ocw2_d = ~data_cap_q[3];
        end
      end else begin
        case (state_q)
          ICW2: begin
            icw24_d = 1'b1;
            bus_d   = data_cap_q;
            state_d = !sngl_q ? ICW3 : (ic4_q ? ICW4 : READY);
          end
          ICW3: begin
            icw24_d = 1'b1;
            bus_d   = data_cap_q;
            state_d = ic4_q ? ICW4 : READY;
          end
          ICW4: begin
            icw24_d = 1'b1;
            bus_d   = data_cap_q;
            state_d = READY;
          end
          READY: begin
            ocw1_d = 1'b1;
            bus_d  = data_cap_q;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_pipe_q   <= '1;
      rd_pipe_q   <= '1;
      wr_pipe_q   <= '1;
      a0_pipe_q   <= '0;
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
      prev_act_q  <= 1'b0;
      armed_q     <= 1'b0;
      a0_cap_q    <= 1'b0;
      data_cap_q  <= '0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      state_q     <= UNINIT;
      bus_q       <= '0;
      icw1_q      <= 1'b0;
      icw24_q     <= 1'b0;
      ocw1_q      <= 1'b0;
      ocw2_q      <= 1'b0;
      ocw3_q      <= 1'b0;
      read_q      <= 1'b0;
    end else begin
      cs_pipe_q   <= cs_pipe_d;
      rd_pipe_q   <= rd_pipe_d;
      wr_pipe_q   <= wr_pipe_d;
      a0_pipe_q   <= a0_pipe_d;
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
      prev_act_q  <= prev_act_d;
      armed_q     <= armed_d;
      a0_cap_q    <= a0_cap_d;
      data_cap_q  <= data_cap_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      state_q     <= state_d;
      bus_q       <= bus_d;
      icw1_q      <= icw1_d;
      icw24_q     <= icw24_d;
      ocw1_q      <= ocw1_d;
      ocw2_q      <= ocw2_d;
      ocw3_q      <= ocw3_d;
      read_q      <= read_d;
    end
  end

  assign internal_data_bus = bus_q;
  assign ICW_1             = icw1_q;
  assign ICW_2_4           = icw24_q;
  assign OCW_1             = ocw1_q;
  assign OCW_2             = ocw2_q;
  assign OCW_3             = ocw3_q;
  assign read              = read_q;
  assign init_done         = (state_q == READY);

endmodule

// File: tb/tb_bus_control_logic.sv
// Directed bench for bus_control_logic (SYNC_STAGES=2): init sequences,
// OCW decode, ignored writes, ICW1 restart, reset-time write and read level.
module tb_bus_control_logic;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3;
  logic       read;
  logic       init_done;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_ICW1  = 5'b10000;
  localparam logic [4:0] P_ICW24 = 5'b01000;
  localparam logic [4:0] P_OCW1  = 5'b00100;
  localparam logic [4:0] P_OCW2  = 5'b00010;
  localparam logic [4:0] P_OCW3  = 5'b00001;

  bus_control_logic #(.SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .chip_select_n     (chip_select_n),
    .read_enable_n     (read_enable_n),
    .write_enable_n    (write_enable_n),
    .address           (address),
    .data_bus_in       (data_bus_in),
    .internal_data_bus (internal_data_bus),
    .ICW_1             (ICW_1),
    .ICW_2_4           (ICW_2_4),
    .OCW_1             (OCW_1),
    .OCW_2             (OCW_2),
    .OCW_3             (OCW_3),
    .read              (read),
    .init_done         (init_done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] pulses();
    return {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chip_select_n  = 1'b1;
    read_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  // WR# is raised #1 after an edge; that next edge is E0, pulse expected at E2.
  task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                          input logic [4:0] exp_p, input logic [7:0] exp_bus);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = a0;
    data_bus_in    = d;
    repeat (3) step();
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("%s_pulse_e%0d", tag, k), {27'd0, pulses()},
          {27'd0, (k == 2) ? exp_p : P_NONE});
    end
    chk({tag, "_bus"}, {24'd0, internal_data_bus}, {24'd0, exp_bus});
    step();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step();
    chk("rst_pulses", {27'd0, pulses()}, 32'd0);
    chk("rst_bus", {24'd0, internal_data_bus}, 32'h00);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // T1: single, IC4 -> ICW3 skipped
    do_write("t1_icw1", 1'b0, 8'h13, P_ICW1, 8'h13);
    do_write("t1_icw2", 1'b1, 8'h20, P_ICW24, 8'h20);
    chk("t1_not_ready", {31'd0, init_done}, 32'd0);
    do_write("t1_icw4", 1'b1, 8'h01, P_ICW24, 8'h01);
    chk("t1_ready", {31'd0, init_done}, 32'd1);

    // T2: cascade, no IC4
    do_write("t2_icw1", 1'b0, 8'h10, P_ICW1, 8'h10);
    do_write("t2_icw2", 1'b1, 8'h08, P_ICW24, 8'h08);
    chk("t2_not_ready", {31'd0, init_done}, 32'd0);
    do_write("t2_icw3", 1'b1, 8'h04, P_ICW24, 8'h04);
    chk("t2_ready", {31'd0, init_done}, 32'd1);
    do_write("t2_ocw1", 1'b1, 8'hFB, P_OCW1, 8'hFB);

    // T3: OCW2 / OCW3 in READY
    do_write("t3_ocw2", 1'b0, 8'h20, P_OCW2, 8'h20);
    do_write("t3_ocw3", 1'b0, 8'h0B, P_OCW3, 8'h0B);
    chk("t3_ready", {31'd0, init_done}, 32'd1);

    // T4: ignored writes in UNINIT, then ICW1 restart from ICW3
    do_reset();
    do_write("t4_a1_uninit", 1'b1, 8'hAA, P_NONE, 8'h00);
    do_write("t4_ocw2_uninit", 1'b0, 8'h20, P_NONE, 8'h00);
    do_write("t4_icw1", 1'b0, 8'h10, P_ICW1, 8'h10);
    do_write("t4_icw2", 1'b1, 8'h11, P_ICW24, 8'h11);
    do_write("t4_restart", 1'b0, 8'h13, P_ICW1, 8'h13);
    do_write("t4_icw2b", 1'b1, 8'h22, P_ICW24, 8'h22);
    chk("t4_not_ready", {31'd0, init_done}, 32'd0);
    do_write("t4_icw4", 1'b1, 8'h01, P_ICW24, 8'h01);
    chk("t4_ready", {31'd0, init_done}, 32'd1);

    // T5a: write active across reset release is discarded
    idle_inputs();
    reset_n        = 1'b0;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'b0;
    data_bus_in    = 8'h13;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (4) step();
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t5_rst_write_e%0d", k), {27'd0, pulses()}, 32'd0);
    end
    chk("t5_rst_write_bus", {24'd0, internal_data_bus}, 32'h00);
    chk("t5_rst_write_uninit", {31'd0, init_done}, 32'd0);

    // T5b: RD# and WR# both low -> read stays 0 (A0=1 in UNINIT is ignored)
    chip_select_n  = 1'b0;
    read_enable_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t5_rdwr_e%0d", k), {31'd0, read}, 32'd0);
    end
    idle_inputs();
    repeat (5) step();

    // T5c: RD# low for 5 edges -> read high on 5 samples after 2-stage pipe
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t5_read_e%0d", k), {31'd0, read}, {31'd0, (k >= 2 && k <= 6)});
      if (k == 4) read_enable_n = 1'b1;
    end
    chip_select_n = 1'b1;
    repeat (2) step();

    // Device re-arms after the discarded write
    do_write("t5_rearm_icw1", 1'b0, 8'h13, P_ICW1, 8'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
